cic_dec_ctrl: RTL and testbench

// - Sequencer for the 3-stage CIC decimator: owns its enable, reset, decimation factor and bypass.
// - Accepts run-time config via valid/ready. On a factor change: flush the filter, discard warm-up outputs, return to RUN.
// - Produces out_valid, a one-cycle strobe marking each new decimated sample at the filter output.

---
 rtl/cic_dec_ctrl.sv | 156 +++++++++++++++
 tb/tb_cic_dec_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/cic_dec_ctrl.sv
// rtl/cic_dec_ctrl.sv - sequencer for a 3-stage CIC decimator: flush, warm-up discard, decimated-sample strobe
// Optional statistics counters are enabled by defining CIC_DEC_CTRL_STATS_EN.
module cic_dec_ctrl #(
    parameter int ORDER        = 3,
    parameter int FLUSH_CYCLES = 2,
    parameter int DEFAULT_DEC  = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [2:0]  cfg_dec_factor,
    input  logic        cfg_bypass,
    output logic        cfg_err,
    output logic        cic_en,
    output logic        cic_rst_n,
    output logic [2:0]  cic_dec_factor,
    output logic        cic_bypass,
    output logic        out_valid,
`ifdef CIC_DEC_CTRL_STATS_EN
    output logic [15:0] reconfig_cnt,
    output logic [15:0] drop_cnt,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        S_FLUSH  = 2'd0,
        S_WARMUP = 2'd1,
        S_RUN    = 2'd2
    } state_t;

    state_t      state_q;
    logic [7:0]  flush_cnt_q;
    logic [7:0]  warm_cnt_q;
    logic [3:0]  phase_q;
    logic        strobe_q;
    logic [2:0]  dec_q;
    logic        byp_q;
    logic        err_q;
    logic        ov_q;

    logic        in_flush;
    logic        accepted;
    logic        strobe;
    logic        cfg_acc;
    logic        cfg_bad;
    logic        cfg_new_dec;
    logic        cfg_new_byp;
    logic        cfg_effect;
    logic [4:0]  blk_len;
    logic        blk_last;

    // The filter is held in reset for the whole flush, so nothing is accepted then.
    assign in_flush    = (state_q == S_FLUSH);
    assign accepted    = in_valid && !in_flush;
    assign strobe      = accepted && strobe_q;
    assign blk_len     = 5'd1 << dec_q;
    assign blk_last    = (phase_q == 4'(blk_len - 5'd1));

    assign cfg_acc     = cfg_valid && cfg_ready;
    assign cfg_bad     = (cfg_dec_factor > 3'd4);
    assign cfg_new_dec = cfg_acc && !cfg_bad && (cfg_dec_factor != dec_q);
    assign cfg_new_byp = cfg_acc && !cfg_bad && (cfg_dec_factor == dec_q) && (cfg_bypass != byp_q);
    // A config that changes anything swallows the strobe of the same cycle.
    assign cfg_effect  = cfg_new_dec || cfg_new_byp;

    assign cfg_ready      = !in_flush;
    assign cic_rst_n      = !in_flush;
    assign cic_en         = accepted;
    assign cic_dec_factor = dec_q;
    assign cic_bypass     = byp_q;
    assign cfg_err        = err_q;
    assign busy           = (state_q != S_RUN);
    // Bypass passes the input strobe straight through; otherwise the registered strobe.
    assign out_valid      = (state_q == S_RUN && byp_q) ? in_valid : ov_q;

    // Sequencer: flush timing, decimation phase, warm-up discard and config application.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FLUSH;
            flush_cnt_q <= 8'd0;
            warm_cnt_q  <= 8'd0;
            phase_q     <= 4'd0;
            strobe_q    <= 1'b0;
            dec_q       <= 3'(DEFAULT_DEC);
            byp_q       <= 1'b0;
            err_q       <= 1'b0;
            ov_q        <= 1'b0;
        end else begin
            err_q <= cfg_acc && cfg_bad;
            ov_q  <= strobe && (state_q == S_RUN) && !byp_q && !cfg_effect;

            if (accepted) begin
                phase_q  <= blk_last ? 4'd0 : phase_q + 4'd1;
                strobe_q <= blk_last;
            end

            case (state_q)
                S_FLUSH: begin
                    if (flush_cnt_q == 8'(FLUSH_CYCLES - 1)) begin
                        state_q     <= S_WARMUP;
                        flush_cnt_q <= 8'd0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 8'd1;
                    end
                end
                S_WARMUP: begin
                    if (byp_q) begin
                        state_q <= S_RUN;
                    end else if (strobe && !cfg_effect) begin
                        if (warm_cnt_q == 8'(ORDER - 1)) begin
                            state_q <= S_RUN;
                        end
                        warm_cnt_q <= warm_cnt_q + 8'd1;
                    end
                end
                default: begin
                end
            endcase

            // A factor change restarts the filter and discards any partial block.
            if (cfg_new_dec) begin
                dec_q       <= cfg_dec_factor;
                byp_q       <= cfg_bypass;
                state_q     <= S_FLUSH;
                flush_cnt_q <= 8'd0;
                warm_cnt_q  <= 8'd0;
                phase_q     <= 4'd0;
                strobe_q    <= 1'b0;
                ov_q        <= 1'b0;
            end else if (cfg_new_byp) begin
                byp_q <= cfg_bypass;
            end
        end
    end

`ifdef CIC_DEC_CTRL_STATS_EN
    // Saturating counters of config-driven flushes and samples dropped while flushing.
    always_ff @(posedge clk) begin
        if (rst) begin
            reconfig_cnt <= 16'd0;
            drop_cnt     <= 16'd0;
        end else begin
            if (cfg_new_dec && reconfig_cnt != 16'hFFFF) begin
                reconfig_cnt <= reconfig_cnt + 16'd1;
            end
            if (in_valid && in_flush && drop_cnt != 16'hFFFF) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_cic_dec_ctrl.sv
// tb/tb_cic_dec_ctrl.sv - self-checking bench for cic_dec_ctrl against a sample-count reference model
module tb_cic_dec_ctrl;

    localparam int ORDER        = 3;
    localparam int FLUSH_CYCLES = 2;
    localparam int DEFAULT_DEC  = 0;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [2:0] cfg_dec_factor;
    logic       cfg_bypass;
    logic       cfg_err;
    logic       cic_en;
    logic       cic_rst_n;
    logic [2:0] cic_dec_factor;
    logic       cic_bypass;
    logic       out_valid;
    logic       busy;
`ifdef CIC_DEC_CTRL_STATS_EN
    logic [15:0] reconfig_cnt;
    logic [15:0] drop_cnt;
`endif

    cic_dec_ctrl #(
        .ORDER(ORDER), .FLUSH_CYCLES(FLUSH_CYCLES), .DEFAULT_DEC(DEFAULT_DEC)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_dec_factor(cfg_dec_factor), .cfg_bypass(cfg_bypass), .cfg_err(cfg_err),
        .cic_en(cic_en), .cic_rst_n(cic_rst_n), .cic_dec_factor(cic_dec_factor),
        .cic_bypass(cic_bypass), .out_valid(out_valid),
`ifdef CIC_DEC_CTRL_STATS_EN
        .reconfig_cnt(reconfig_cnt), .drop_cnt(drop_cnt),
`endif
        .busy(busy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int ov_seen = 0;

    // Reference model: counts accepted samples since the filter left reset.
    int       m_flush_left;
    bit       m_warm;
    int       m_n;
    int       m_strobes;
    int       m_fac;
    bit       m_byp;
    bit       m_ov;
    bit       m_err;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_flush_left = FLUSH_CYCLES;
        m_warm       = 1'b0;
        m_n          = 0;
        m_strobes    = 0;
        m_fac        = DEFAULT_DEC;
        m_byp        = 1'b0;
        m_ov         = 1'b0;
        m_err        = 1'b0;
    endtask

    // Drive one cycle, compare against the model, then advance model and clock together.
    task automatic step(input bit iv, input bit cv, input int cf, input bit cb, input bit r);
        bit flush, acc_s, strobe, acc_c, bad, eff_fac, eff_byp, eff, exp_ov;
        int d;
        rst = r; in_valid = iv; cfg_valid = cv; cfg_dec_factor = 3'(cf); cfg_bypass = cb;
        #1;
        flush  = (m_flush_left > 0);
        exp_ov = (!flush && !m_warm && m_byp) ? iv : m_ov;
        chk("cic_rst_n", 16'(cic_rst_n), 16'(!flush));
        chk("cfg_ready", 16'(cfg_ready), 16'(!flush));
        chk("cic_en", 16'(cic_en), 16'(iv && !flush));
        chk("busy", 16'(busy), 16'(flush || m_warm));
        chk("out_valid", 16'(out_valid), 16'(exp_ov));
        chk("cfg_err", 16'(cfg_err), 16'(m_err));
        chk("cic_dec_factor", 16'(cic_dec_factor), 16'(m_fac));
        chk("cic_bypass", 16'(cic_bypass), 16'(m_byp));
        if (out_valid === 1'b1) ov_seen++;

        if (r) begin
            model_reset();
        end else begin
            d       = 1 << m_fac;
            acc_s   = iv && !flush;
            strobe  = acc_s && (m_n > 0) && (m_n % d == 0);
            acc_c   = cv && !flush;
            bad     = (cf > 4);
            eff_fac = acc_c && !bad && (cf != m_fac);
            eff_byp = acc_c && !bad && (cf == m_fac) && (cb != m_byp);
            eff     = eff_fac || eff_byp;
            m_err   = acc_c && bad;
            m_ov    = strobe && !flush && !m_warm && !m_byp && !eff;
            if (acc_s) m_n++;
            if (flush) begin
                m_flush_left--;
                if (m_flush_left == 0) begin
                    m_warm = 1'b1; m_n = 0; m_strobes = 0;
                end
            end else if (m_warm) begin
                if (m_byp) begin
                    m_warm = 1'b0;
                end else if (strobe && !eff) begin
                    m_strobes++;
                    if (m_strobes == ORDER) m_warm = 1'b0;
                end
            end
            if (eff_fac) begin
                m_fac = cf; m_byp = cb; m_flush_left = FLUSH_CYCLES;
                m_warm = 1'b0; m_n = 0; m_strobes = 0; m_ov = 1'b0;
            end else if (eff_byp) begin
                m_byp = cb;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_run(input int cycles, input bit iv);
        for (int i = 0; i < cycles; i++) step(iv, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        int cf;
        rst = 1'b1; in_valid = 1'b0; cfg_valid = 1'b0; cfg_dec_factor = 3'd0; cfg_bypass = 1'b0;
        model_reset();
        @(posedge clk); #1;
        @(posedge clk); #1;

        // Reset state
        rst = 1'b0; #1;
        chk("rst_busy", 16'(busy), 16'd1);
        chk("rst_cic_rst_n", 16'(cic_rst_n), 16'd0);
        chk("rst_out_valid", 16'(out_valid), 16'd0);
        chk("rst_dec", 16'(cic_dec_factor), 16'(DEFAULT_DEC));

        // D=1, constant input: flush, three discarded strobes, then every cycle
        idle_run(12, 1'b1);
        ov_seen = 0;
        idle_run(8, 1'b1);
        chk("d1_cadence", 16'(ov_seen), 16'd8);

        // D=8: flush and warm-up, then one output per 8 samples
        step(1'b1, 1'b1, 3, 1'b0, 1'b0);
        idle_run(40, 1'b1);
        ov_seen = 0;
        idle_run(32, 1'b1);
        chk("d8_cadence", 16'(ov_seen), 16'd4);

        // Illegal factor: error pulse, cadence unbroken
        step(1'b1, 1'b1, 5, 1'b1, 1'b0);
        chk("err_dec_kept", 16'(cic_dec_factor), 16'd3);
        ov_seen = 0;
        idle_run(31, 1'b1);
        chk("d8_after_err", 16'(ov_seen), 16'd4);

        // D=4 with a bypass toggle and no flush
        step(1'b1, 1'b1, 2, 1'b0, 1'b0);
        idle_run(24, 1'b1);
        step(1'b1, 1'b1, 2, 1'b1, 1'b0);
        for (int i = 0; i < 12; i++) step(1'($urandom_range(0, 1)), 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 2, 1'b0, 1'b0);
        idle_run(20, 1'b1);

        // D=2, 50% input duty
        step(1'b1, 1'b1, 1, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) step(1'(i % 2), 1'b0, 0, 1'b0, 1'b0);
        ov_seen = 0;
        for (int i = 0; i < 40; i++) step(1'(i % 2), 1'b0, 0, 1'b0, 1'b0);
        chk("d2_half_duty", 16'(ov_seen), 16'd10);

        // Factor change mid-block, then reset during warm-up
        step(1'b1, 1'b0, 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 4, 1'b0, 1'b0);
        idle_run(5, 1'b1);
        chk("warm_busy", 16'(busy), 16'd1);
        step(1'b1, 1'b0, 0, 1'b0, 1'b1);
        chk("rst2_dec", 16'(cic_dec_factor), 16'(DEFAULT_DEC));
        chk("rst2_rst_n", 16'(cic_rst_n), 16'd0);
        chk("rst2_out_valid", 16'(out_valid), 16'd0);
        idle_run(10, 1'b1);

        // Randomized traffic with occasional config and reset
        for (int i = 0; i < 4000; i++) begin
            cf = ($urandom_range(0, 9) == 0) ? 5 : int'($urandom_range(0, 4));
            step(1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 39) == 0),
                 cf,
                 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 799) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
